// File: rtl/pci_arb_pkg.sv
// Shared types and constants for the central PCI bus arbiter.
package pci_arb_pkg;

  // Arbiter FSM states
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_GRANTED = 3'd1,
    ST_BUSY    = 3'd2,
    ST_REVOKED = 3'd3,
    ST_GAP     = 3'd4
  } arb_state_e;

  localparam int DEF_N_MASTERS     = 4;
  localparam int DEF_GRANT_TIMEOUT = 16;
  localparam int OWNER_W           = $clog2(DEF_N_MASTERS);

  // Owner-index width for a given master count (never below one bit)
  function automatic int owner_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pci_rr_pick.sv
// Combinational round-robin picker: first requester after the pointer wins.
module pci_rr_pick #(
  parameter int N  = 4,
  parameter int OW = 2
) (
  input  logic [N-1:0]  i_req,
  input  logic [OW-1:0] i_ptr,
  output logic [OW-1:0] o_idx,
  output logic          o_vld
);

  // Scan ptr+1 .. ptr+N (mod N) and keep the first hit
  always_comb begin
    o_idx = '0;
    o_vld = 1'b0;
    for (int k = 1; k <= N; k++) begin
      int t;
      t = (int'(i_ptr) + k) % N;
      if (!o_vld && i_req[t]) begin
        o_idx = OW'(t);
        o_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pci_bus_arbiter.sv
// Central PCI arbiter: round-robin grants, bus parking, hidden arbitration
// during a transaction and a grant-idle timeout. All outputs registered.
module pci_bus_arbiter
  import pci_arb_pkg::*;
#(
  parameter int N_MASTERS     = DEF_N_MASTERS,
  parameter int PARK_EN       = 1,
  parameter int PARK_MASTER   = 0,
  parameter int GRANT_TIMEOUT = DEF_GRANT_TIMEOUT
) (
  input  logic                         PCI_CLK,
  input  logic                         RESET_n,
  input  logic [N_MASTERS-1:0]         REQ_n,
  input  logic                         FRAME_n,
  input  logic                         IRDY_n,
  output logic [N_MASTERS-1:0]         GNT_n,
  output logic [$clog2(N_MASTERS)-1:0] OWNER,
  output logic                         OWNER_VALID,
  output logic                         BUS_IDLE
);

  localparam int OW = owner_w(N_MASTERS);
  localparam int CW = $clog2(GRANT_TIMEOUT + 1);

  arb_state_e           r_state, n_state;
  logic [N_MASTERS-1:0] r_gnt_n, n_gnt_n;
  logic [OW-1:0]        r_owner, n_owner;
  logic                 r_valid, n_valid;
  logic [OW-1:0]        r_ptr, n_ptr;
  logic [OW-1:0]        r_win, n_win;
  logic [CW-1:0]        r_cnt, n_cnt;
  logic                 r_parked, n_parked;
  logic                 r_bus_idle;

  logic [N_MASTERS-1:0] w_req, w_own_mask, w_pick_req;
  logic                 w_idle, w_other;
  logic [OW-1:0]        w_win;
  logic                 w_win_vld;

  // Active-low grant vector with only bit idx asserted
  function automatic logic [N_MASTERS-1:0] gnt_of(input logic [OW-1:0] idx);
    return ~(N_MASTERS'(1) << idx);
  endfunction

  assign w_req      = ~REQ_n;
  assign w_idle     = FRAME_n & IRDY_n;
  assign w_own_mask = N_MASTERS'(1) << r_owner;
  assign w_other    = |(w_req & ~w_own_mask);
  // During a transaction only the other masters compete for the next slot
  assign w_pick_req = (r_state == ST_BUSY) ? (w_req & ~w_own_mask) : w_req;

  pci_rr_pick #(.N(N_MASTERS), .OW(OW)) u_pick (
    .i_req (w_pick_req),
    .i_ptr (r_ptr),
    .o_idx (w_win),
    .o_vld (w_win_vld)
  );

  // Next-state, grant and bookkeeping decode
  always_comb begin
    n_state  = r_state;
    n_gnt_n  = r_gnt_n;
    n_owner  = r_owner;
    n_valid  = r_valid;
    n_ptr    = r_ptr;
    n_win    = r_win;
    n_cnt    = r_cnt;
    n_parked = r_parked;
    unique case (r_state)
      ST_IDLE, ST_GAP: begin
        n_cnt = '0;
        if (w_win_vld) begin
          n_gnt_n  = gnt_of(w_win);
          n_owner  = w_win;
          n_valid  = 1'b1;
          n_parked = 1'b0;
          n_state  = ST_GRANTED;
        end else if (PARK_EN != 0) begin
          n_gnt_n  = gnt_of(OW'(PARK_MASTER));
          n_owner  = OW'(PARK_MASTER);
          n_valid  = 1'b1;
          n_parked = 1'b1;
          n_state  = ST_GRANTED;
        end else begin
          n_state  = ST_IDLE;
        end
      end
      ST_GRANTED: begin
        // Count only idle clocks that starve another requester
        n_cnt = (w_idle && w_other) ? r_cnt + CW'(1) : '0;
        if (!FRAME_n) begin
          n_state  = ST_BUSY;
          n_cnt    = '0;
          n_ptr    = r_owner;
          n_parked = 1'b0;
        end else if (r_parked) begin
          if (w_req[r_owner]) begin
            n_parked = 1'b0;           // park master asked: keep grant, no gap
          end else if (|w_req) begin
            n_gnt_n = '1;
            n_valid = 1'b0;
            n_cnt   = '0;
            n_state = ST_GAP;
          end
        end else if (!w_req[r_owner]) begin
          n_gnt_n = '1;
          n_valid = 1'b0;
          n_cnt   = '0;
          n_state = ST_GAP;
        end else if (w_idle && w_other && r_cnt == CW'(GRANT_TIMEOUT - 1)) begin
          n_gnt_n = '1;
          n_valid = 1'b0;
          n_cnt   = '0;
          n_ptr   = r_owner;
          n_state = ST_GAP;
        end
      end
      ST_BUSY: begin
        if (w_other) begin
          // Hidden arbitration: pull GNT# while FRAME# is still active
          n_gnt_n = '1;
          n_valid = 1'b0;
          n_win   = w_win;
          n_state = ST_REVOKED;
        end else if (w_idle) begin
          n_cnt   = '0;
          n_state = ST_GRANTED;
        end
      end
      ST_REVOKED: begin
        if (w_idle) begin
          n_cnt = '0;
          if (w_req[r_win]) begin
            n_gnt_n = gnt_of(r_win);
            n_owner = r_win;
            n_valid = 1'b1;
            n_state = ST_GRANTED;
          end else if (w_win_vld) begin
            n_gnt_n = gnt_of(w_win);
            n_owner = w_win;
            n_valid = 1'b1;
            n_state = ST_GRANTED;
          end else begin
            n_state = ST_IDLE;
          end
        end
      end
      default: begin
        n_gnt_n = '1;
        n_valid = 1'b0;
        n_state = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset pulls every GNT# high at once
  always_ff @(posedge PCI_CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      r_state    <= ST_IDLE;
      r_gnt_n    <= '1;
      r_owner    <= '0;
      r_valid    <= 1'b0;
      r_ptr      <= OW'(N_MASTERS - 1);
      r_win      <= '0;
      r_cnt      <= '0;
      r_parked   <= 1'b0;
      r_bus_idle <= 1'b1;
    end else begin
      r_state    <= n_state;
      r_gnt_n    <= n_gnt_n;
      r_owner    <= n_owner;
      r_valid    <= n_valid;
      r_ptr      <= n_ptr;
      r_win      <= n_win;
      r_cnt      <= n_cnt;
      r_parked   <= n_parked;
      r_bus_idle <= w_idle;
    end
  end

  assign GNT_n       = r_gnt_n;
  assign OWNER       = $clog2(N_MASTERS)'(r_owner);
  assign OWNER_VALID = r_valid;
  assign BUS_IDLE    = r_bus_idle;

endmodule
